// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : 8N1 UART receiver with 2-flop input synchronizer, mid-bit
//               sampling, good-frame and frame-error strobes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_err
);

    localparam int CW = $clog2(CLKS_PER_BIT);

    localparam logic [CW-1:0] c_CNT_MAX  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] c_CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_START = 2'd1;
    localparam logic [1:0] c_DATA  = 2'd2;
    localparam logic [1:0] c_STOP  = 2'd3;

    logic [1:0]    r_state;
    logic [1:0]    w_state_nxt;
    logic          r_rx_meta;
    logic          r_rx_s;
    logic          r_rx_s_d;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_bit_idx;
    logic [7:0]    r_shift;
    logic [7:0]    r_rx_data;
    logic          r_rx_valid;
    logic          r_frame_err;

    logic w_fall;
    logic w_half;
    logic w_full;
    logic w_busy;
    logic w_data_sample;
    logic w_stop_sample;
    logic w_cnt_clr;
    logic w_idx_clr;

    assign w_fall = r_rx_s_d & ~r_rx_s;
    assign w_half = (r_cnt == c_CNT_HALF);
    assign w_full = (r_cnt == c_CNT_MAX);

    // Synchronizer idles high so reset release never looks like a start edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_s_d  <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_s_d  <= r_rx_s;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE:  if (w_fall) w_state_nxt = c_START;
            c_START: if (w_half) w_state_nxt = r_rx_s ? c_IDLE : c_DATA;
            c_DATA:  if (w_full && (r_bit_idx == 3'd7)) w_state_nxt = c_STOP;
            c_STOP:  if (w_full) w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_comb begin
        w_busy        = (r_state != c_IDLE);
        w_data_sample = (r_state == c_DATA) && w_full;
        w_stop_sample = (r_state == c_STOP) && w_full;
        w_idx_clr     = (r_state == c_START) && w_half;
        w_cnt_clr     = ((r_state == c_IDLE) && w_fall) || w_idx_clr
                      || w_data_sample || w_stop_sample;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_rx_data   <= 8'h00;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            if (w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_busy) begin
                r_cnt <= r_cnt + 1'b1;
            end

            if (w_idx_clr) begin
                r_bit_idx <= 3'd0;
            end else if (w_data_sample) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            if (w_data_sample) begin
                r_shift[r_bit_idx] <= r_rx_s;
            end

            // Stop bit decides between committing the byte and flagging an error
            r_rx_valid  <= w_stop_sample & r_rx_s;
            r_frame_err <= w_stop_sample & ~r_rx_s;
            if (w_stop_sample && r_rx_s) begin
                r_rx_data <= r_shift;
            end
        end
    end

    assign rx_data   = r_rx_data;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign rx_busy   = w_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ============================================================================
// Module      : tb_uart_rx
// Description : Directed bench for uart_rx with a timing-based reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = CPB / 2;

    logic       clk;
    logic       rst;
    logic       rx;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_err;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_busy   (rx_busy),
        .frame_err (frame_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: frame timing measured as cycles elapsed since the start edge
    bit       m_started = 1'b0;
    bit       m_s1 = 1'b1, m_s = 1'b1, m_sd = 1'b1;
    bit       m_active = 1'b0;
    int       m_el = 0;
    int       m_k = 0;
    bit [7:0] m_shift = 8'h00;
    bit [7:0] exp_data = 8'h00;
    bit       exp_valid = 1'b0;
    bit       exp_err = 1'b0;

    always @(posedge clk) begin
        cyc++;
        m_started = 1'b1;
        if (rst) begin
            m_s1 = 1'b1; m_s = 1'b1; m_sd = 1'b1;
            m_active = 1'b0; m_el = 0; m_shift = 8'h00;
            exp_data = 8'h00; exp_valid = 1'b0; exp_err = 1'b0;
        end else begin
            exp_valid = 1'b0;
            exp_err   = 1'b0;
            if (!m_active) begin
                if (m_sd && !m_s) begin
                    m_active = 1'b1;
                    m_el = 0;
                end
            end else begin
                if (m_el == HALF - 1) begin
                    if (m_s) m_active = 1'b0;
                end else if (m_el > HALF - 1 && ((m_el - (HALF - 1)) % CPB) == 0) begin
                    m_k = (m_el - (HALF - 1)) / CPB;
                    if (m_k <= 8) begin
                        m_shift[m_k - 1] = m_s;
                    end else begin
                        m_active = 1'b0;
                        if (m_s) begin
                            exp_data  = m_shift;
                            exp_valid = 1'b1;
                        end else begin
                            exp_err = 1'b1;
                        end
                    end
                end
                m_el++;
            end
            m_sd = m_s;
            m_s  = m_s1;
            m_s1 = rx;
        end
    end

    // Per-cycle comparison plus pulse bookkeeping for the directed checks
    bit [7:0] vdata[$];
    int       vcyc[$];
    int       n_err = 0;

    always @(negedge clk) begin
        if (m_started) begin
            check("rx_data",   {24'h0, rx_data}, {24'h0, exp_data});
            check("rx_valid",  {31'h0, rx_valid}, {31'h0, exp_valid});
            check("frame_err", {31'h0, frame_err}, {31'h0, exp_err});
            check("rx_busy",   {31'h0, rx_busy}, {31'h0, m_active});
        end
        if (rx_valid === 1'b1) begin
            vdata.push_back(rx_data);
            vcyc.push_back(cyc);
        end
        if (frame_err === 1'b1) n_err++;
    end

    task automatic drive(input bit v, input int n);
        repeat (n) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    task automatic send_byte(input bit [7:0] b, input bit stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    int v0, e0;

    initial begin
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_data",  {24'h0, rx_data}, 32'h00);
        check("reset_valid", {31'h0, rx_valid}, 32'h0);
        check("reset_err",   {31'h0, frame_err}, 32'h0);
        check("reset_busy",  {31'h0, rx_busy}, 32'h0);
        rst = 1'b0;
        drive(1'b1, 20);

        // Good frame
        v0 = vdata.size(); e0 = n_err;
        send_byte(8'hA5, 1'b1);
        drive(1'b1, 20);
        check("a5_count", vdata.size() - v0, 1);
        check("a5_data",  {24'h0, vdata[vdata.size()-1]}, 32'hA5);
        check("a5_noerr", n_err - e0, 0);
        check("a5_idle",  {31'h0, rx_busy}, 32'h0);

        // Bad stop bit
        v0 = vdata.size(); e0 = n_err;
        send_byte(8'h3C, 1'b0);
        drive(1'b1, 20);
        check("3c_err",   n_err - e0, 1);
        check("3c_nodv",  vdata.size() - v0, 0);
        check("3c_hold",  {24'h0, rx_data}, 32'hA5);

        // Glitch shorter than half a bit
        v0 = vdata.size(); e0 = n_err;
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("glitch_nodv",  vdata.size() - v0, 0);
        check("glitch_noerr", n_err - e0, 0);
        check("glitch_idle",  {31'h0, rx_busy}, 32'h0);

        // Back-to-back frames
        v0 = vdata.size(); e0 = n_err;
        send_byte(8'h00, 1'b1);
        send_byte(8'hFF, 1'b1);
        drive(1'b1, 20);
        check("b2b_count", vdata.size() - v0, 2);
        if (vdata.size() - v0 == 2) begin
            check("b2b_first",  {24'h0, vdata[v0]}, 32'h00);
            check("b2b_second", {24'h0, vdata[v0+1]}, 32'hFF);
            check("b2b_gap",    vcyc[v0+1] - vcyc[v0], 160);
        end

        // Reset during data bit 3
        v0 = vdata.size(); e0 = n_err;
        drive(1'b0, CPB);
        for (int i = 0; i < 3; i++) drive(1'b0 ^ ((8'h12 >> i) & 1), CPB);
        drive(1'b0, CPB / 2);
        @(negedge clk);
        rst = 1'b1;
        rx  = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_data", {24'h0, rx_data}, 32'h00);
        drive(1'b1, 20);
        send_byte(8'h5A, 1'b1);
        drive(1'b1, 20);
        check("rst_count", vdata.size() - v0, 1);
        check("rst_data2", {24'h0, vdata[vdata.size()-1]}, 32'h5A);
        check("rst_noerr", n_err - e0, 0);

        // Break condition
        v0 = vdata.size(); e0 = n_err;
        drive(1'b0, 30 * CPB);
        drive(1'b1, 32);
        check("brk_err",  n_err - e0, 1);
        check("brk_nodv", vdata.size() - v0, 0);
        send_byte(8'h81, 1'b1);
        drive(1'b1, 20);
        check("brk_count", vdata.size() - v0, 1);
        check("brk_data",  {24'h0, vdata[vdata.size()-1]}, 32'h81);
        check("brk_err2",  n_err - e0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
